complex_mul_pipe: RTL and testbench

COMPLEX_MUL_PIPE -- requirements
Module: complex_mul_pipe

---
 rtl/complex_mul_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_complex_mul_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mul_pipe.sv
// complex_mul_pipe: three-stage fixed-point complex multiplier with
// a*b, a*conj(b) and |a|^2 modes, round-half-up, saturation and a
// saturation event counter. A single global enable stalls the whole
// pipeline when the output is holding a result nobody has taken yet.
module complex_mul_pipe #(
  parameter int W     = 32,
  parameter int FRAC  = 31,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y_re,
  output logic signed [W-1:0] y_im,
  output logic                y_sat,
  output logic                sat_sticky,
  output logic [CNT_W-1:0]    sat_count,
  input  logic                sat_clr
);

  localparam int PW = 2 * W;
  localparam int TW = PW + 1;
  localparam int RW = W + 2;
  localparam logic signed [TW-1:0] HALF = TW'(1) <<< (FRAC - 1);
  localparam logic signed [RW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_CONJ = 2'd1,
    MODE_MAG2 = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Full-precision signed product of two W-bit operands
  function automatic logic signed [PW-1:0] smul(input logic signed [W-1:0] x,
                                                 input logic signed [W-1:0] y);
    return $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
  endfunction

  // Round half up and drop FRAC fraction bits, keeping W+2 signed bits
  function automatic logic signed [RW-1:0] rnd(input logic signed [PW-1:0] p);
    logic signed [TW-1:0] t;
    t = $signed({p[PW-1], p}) + HALF;
    return RW'(t >>> FRAC);
  endfunction

  logic en;
  mode_e in_mode_e;

  logic                s1_valid_q, s1_valid_d;
  mode_e               s1_mode_q, s1_mode_d;
  logic signed [W-1:0] s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic signed [W-1:0] s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;

  logic                 s2_valid_q, s2_valid_d;
  mode_e                s2_mode_q, s2_mode_d;
  logic signed [PW-1:0] s2_p0_q, s2_p0_d, s2_p1_q, s2_p1_d;
  logic signed [PW-1:0] s2_p2_q, s2_p2_d, s2_p3_q, s2_p3_d;
  logic signed [W-1:0]  sel_re, sel_im;

  logic signed [RW-1:0] r0, r1, r2, r3, sum_re, sum_im;
  logic signed [W-1:0]  clip_re, clip_im;
  logic                 sat_re, sat_im;

  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
  logic                y_sat_q, y_sat_d;
  logic                sat_sticky_q, sat_sticky_d;
  logic [CNT_W-1:0]    sat_count_q, sat_count_d;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign in_mode_e = mode_e'(in_mode);

  assign out_valid  = out_valid_q;
  assign y_re       = y_re_q;
  assign y_im       = y_im_q;
  assign y_sat      = y_sat_q;
  assign sat_sticky = sat_sticky_q;
  assign sat_count  = sat_count_q;

  // Stage 1: capture the accepted beat, folding the reserved mode into a*b
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_a_re_d  = s1_a_re_q;
    s1_a_im_d  = s1_a_im_q;
    s1_b_re_d  = s1_b_re_q;
    s1_b_im_d  = s1_b_im_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = (in_mode_e == MODE_RSVD) ? MODE_MUL : in_mode_e;
        s1_a_re_d = a_re;
        s1_a_im_d = a_im;
        s1_b_re_d = b_re;
        s1_b_im_d = b_im;
      end
    end
  end

  // Stage 2: four products; |a|^2 squares a instead of using b
  always_comb begin
    sel_re     = (s1_mode_q == MODE_MAG2) ? s1_a_re_q : s1_b_re_q;
    sel_im     = (s1_mode_q == MODE_MAG2) ? s1_a_im_q : s1_b_im_q;
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_p0_d    = s2_p0_q;
    s2_p1_d    = s2_p1_q;
    s2_p2_d    = s2_p2_q;
    s2_p3_d    = s2_p3_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_p0_d   = smul(s1_a_re_q, sel_re);
        s2_p1_d   = smul(s1_a_im_q, sel_im);
        s2_p2_d   = smul(s1_a_re_q, s1_b_im_q);
        s2_p3_d   = smul(s1_a_im_q, s1_b_re_q);
      end
    end
  end

  // Stage 3 datapath: round each product, combine per mode, then clip
  always_comb begin
    r0 = rnd(s2_p0_q);
    r1 = rnd(s2_p1_q);
    r2 = rnd(s2_p2_q);
    r3 = rnd(s2_p3_q);
    case (s2_mode_q)
      MODE_CONJ: begin
        sum_re = r0 + r1;
        sum_im = r3 - r2;
      end
      MODE_MAG2: begin
        sum_re = r0 + r1;
        sum_im = '0;
      end
      default: begin
        sum_re = r0 - r1;
        sum_im = r2 + r3;
      end
    endcase
    sat_re  = 1'b0;
    sat_im  = 1'b0;
    clip_re = sum_re[W-1:0];
    clip_im = sum_im[W-1:0];
    if (sum_re > MAXV) begin
      clip_re = {1'b0, {(W-1){1'b1}}};
      sat_re  = 1'b1;
    end else if (sum_re < MINV) begin
      clip_re = {1'b1, {(W-1){1'b0}}};
      sat_re  = 1'b1;
    end
    if (sum_im > MAXV) begin
      clip_im = {1'b0, {(W-1){1'b1}}};
      sat_im  = 1'b1;
    end else if (sum_im < MINV) begin
      clip_im = {1'b1, {(W-1){1'b0}}};
      sat_im  = 1'b1;
    end
  end

  // Stage 3 register: load a new result or bubble only when the pipe advances
  always_comb begin
    out_valid_d = out_valid_q;
    y_re_d      = y_re_q;
    y_im_d      = y_im_q;
    y_sat_d     = y_sat_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        y_re_d  = clip_re;
        y_im_d  = clip_im;
        y_sat_d = sat_re || sat_im;
      end
    end
  end

  // Saturation statistics count delivered results only; clear wins
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_count_d  = sat_count_q;
    if (sat_clr) begin
      sat_sticky_d = 1'b0;
      sat_count_d  = '0;
    end else if (out_valid_q && out_ready && y_sat_q) begin
      sat_sticky_d = 1'b1;
      if (!(&sat_count_q)) begin
        sat_count_d = sat_count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops every beat in flight and the statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= MODE_MUL;
      s1_a_re_q    <= '0;
      s1_a_im_q    <= '0;
      s1_b_re_q    <= '0;
      s1_b_im_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_mode_q    <= MODE_MUL;
      s2_p0_q      <= '0;
      s2_p1_q      <= '0;
      s2_p2_q      <= '0;
      s2_p3_q      <= '0;
      out_valid_q  <= 1'b0;
      y_re_q       <= '0;
      y_im_q       <= '0;
      y_sat_q      <= 1'b0;
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_a_re_q    <= s1_a_re_d;
      s1_a_im_q    <= s1_a_im_d;
      s1_b_re_q    <= s1_b_re_d;
      s1_b_im_q    <= s1_b_im_d;
      s2_valid_q   <= s2_valid_d;
      s2_mode_q    <= s2_mode_d;
      s2_p0_q      <= s2_p0_d;
      s2_p1_q      <= s2_p1_d;
      s2_p2_q      <= s2_p2_d;
      s2_p3_q      <= s2_p3_d;
      out_valid_q  <= out_valid_d;
      y_re_q       <= y_re_d;
      y_im_q       <= y_im_d;
      y_sat_q      <= y_sat_d;
      sat_sticky_q <= sat_sticky_d;
      sat_count_q  <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Testbench for complex_mul_pipe: scenario tasks driving randomized and
// directed beats, checked against a plain-arithmetic reference model.
module tb_complex_mul_pipe;

  localparam int W       = 32;
  localparam int FRAC    = 31;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [1:0]          in_mode = 2'd0;
  logic signed [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] y_re, y_im;
  logic                y_sat, sat_sticky;
  logic [CW-1:0]       sat_count;
  logic                sat_clr = 1'b0;

  always #5 clk = ~clk;

  complex_mul_pipe #(.W(W), .FRAC(FRAC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im),
    .y_sat(y_sat), .sat_sticky(sat_sticky), .sat_count(sat_count),
    .sat_clr(sat_clr)
  );

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic                sat;
  } res_t;

  res_t exp_q[$];
  res_t exp_r;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  logic model_sticky = 1'b0;

  logic                o_in_ready, o_out_valid, o_y_sat, o_sticky;
  logic signed [W-1:0] o_y_re, o_y_im;
  logic [CW-1:0]       o_count;
  logic                hs, exp_have, exp_sticky;
  int                  exp_cnt;

  function automatic longint rnd_m(input longint p);
    return (p + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
  endfunction

  // Reference: exact integer arithmetic of the complex operation, then clip
  function automatic res_t model(input logic [1:0] mode,
                                 input logic signed [W-1:0] ar, ai, br, bi);
    longint xr, xi, yr, yi, re, im;
    res_t r;
    xr = ar; xi = ai; yr = br; yi = bi;
    case (mode)
      2'd1: begin
        re = rnd_m(xr * yr) + rnd_m(xi * yi);
        im = rnd_m(xi * yr) - rnd_m(xr * yi);
      end
      2'd2: begin
        re = rnd_m(xr * xr) + rnd_m(xi * xi);
        im = 0;
      end
      default: begin
        re = rnd_m(xr * yr) - rnd_m(xi * yi);
        im = rnd_m(xr * yi) + rnd_m(xi * yr);
      end
    endcase
    r.sat = 1'b0;
    if (re > 64'sd2147483647) begin r.re = 32'h7FFF_FFFF; r.sat = 1'b1; end
    else if (re < -64'sd2147483648) begin r.re = 32'h8000_0000; r.sat = 1'b1; end
    else r.re = re[31:0];
    if (im > 64'sd2147483647) begin r.im = 32'h7FFF_FFFF; r.sat = 1'b1; end
    else if (im < -64'sd2147483648) begin r.im = 32'h8000_0000; r.sat = 1'b1; end
    else r.im = im[31:0];
    return r;
  endfunction

  function automatic logic signed [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'sh8000_0000;
      1: return 32'sh7FFF_FFFF;
      2: return '0;
      default: return $urandom();
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, sample 1ns later, update model
  task automatic step(input logic iv, input logic [1:0] md,
                      input logic signed [W-1:0] ar, ai, br, bi,
                      input logic ordy, input logic clr);
    @(negedge clk);
    in_valid = iv; in_mode = md; a_re = ar; a_im = ai; b_re = br; b_im = bi;
    out_ready = ordy; sat_clr = clr;
    #1;
    o_in_ready = in_ready; o_out_valid = out_valid; o_y_re = y_re;
    o_y_im = y_im; o_y_sat = y_sat; o_sticky = sat_sticky; o_count = sat_count;
    exp_cnt = model_cnt;
    exp_sticky = model_sticky;
    hs = o_out_valid && ordy;
    exp_have = 1'b0;
    if (hs && exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      exp_have = 1'b1;
    end
    if (clr) begin
      model_cnt = 0;
      model_sticky = 1'b0;
    end else if (hs && exp_have && exp_r.sat) begin
      model_sticky = 1'b1;
      if (model_cnt < CNT_MAX) model_cnt++;
    end
    if (iv && o_in_ready) exp_q.push_back(model(md, ar, ai, br, bi));
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    total++;
    if ({out_valid, y_sat, sat_sticky} !== 3'b000)
      $display("[TB] FAIL reset_flags: got %b expected 000", {out_valid, y_sat, sat_sticky});
    if ({out_valid, y_sat, sat_sticky} !== 3'b000) bad++;
    total++;
    if (y_re !== 0 || y_im !== 0) begin
      bad++;
      $display("[TB] FAIL reset_y: got %h/%h expected 0/0", y_re, y_im);
    end
    total++;
    if (sat_count !== 0) begin
      bad++;
      $display("[TB] FAIL reset_count: got %0d expected 0", sat_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    total++;
    if (o_in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", o_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  md[5];
    logic [31:0] ar[5], ai[5], br[5], bi[5], er[5], ei[5];
    logic        es[5];
    $display("[TB] test_directed");
    md = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    ar = '{32'h4000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 32'h4000_0000};
    ai = '{32'h0, 32'h0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    br = '{32'h4000_0000, 32'h8000_0000, 32'h0, 32'h1234_5678, 32'h4000_0000};
    bi = '{32'h0, 32'h0, 32'h4000_0000, 32'h7EDC_BA98, 32'h0};
    er = '{32'h2000_0000, 32'h7FFF_FFFF, 32'h2000_0000, 32'h4000_0000, 32'h2000_0000};
    ei = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2000_0000};
    es = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1, md[i], ar[i], ai[i], br[i], bi[i], 1'b1, 1'b0);
      total++;
      if (o_count !== CW'(exp_cnt) || o_sticky !== exp_sticky) begin
        bad++;
        $display("[TB] FAIL directed_stats[%0d]: got %0d/%b expected %0d/%b",
                 i, o_count, o_sticky, exp_cnt, exp_sticky);
      end
      for (int k = 1; k <= 3; k++) begin
        step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        total++;
        if (o_out_valid !== (k == 3)) begin
          bad++;
          $display("[TB] FAIL latency[%0d] cycle %0d: got out_valid=%b expected %b",
                   i, k, o_out_valid, (k == 3));
        end
        if (k == 3) begin
          total++;
          if (o_y_re !== er[i] || o_y_im !== ei[i] || o_y_sat !== es[i]) begin
            bad++;
            $display("[TB] FAIL directed[%0d]: got %h/%h/%b expected %h/%h/%b",
                     i, o_y_re, o_y_im, o_y_sat, er[i], ei[i], es[i]);
          end
        end
      end
    end
    step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    total++;
    if (o_count !== CW'(1) || o_sticky !== 1'b1) begin
      bad++;
      $display("[TB] FAIL directed_sat_count: got %0d/%b expected 1/1", o_count, o_sticky);
    end
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic ordy;
    logic [1:0] md;
    logic signed [W-1:0] ar, ai, br, bi;
    $display("[TB] test_backpressure");
    sent = 0; got = 0;
    md = 2'($urandom_range(0, 3)); ar = rand_op(); ai = rand_op(); br = rand_op(); bi = rand_op();
    for (int c = 0; c < 200 && got < 8; c++) begin
      ordy = (c % 3 == 0);
      step(sent < 8, md, ar, ai, br, bi, ordy, 1'b0);
      total++;
      if (o_in_ready !== !(o_out_valid && !ordy)) begin
        bad++;
        $display("[TB] FAIL bp_in_ready: got %b expected %b", o_in_ready, !(o_out_valid && !ordy));
      end
      if (hs) begin
        got++;
        total++;
        if ({exp_have, o_y_re, o_y_im, o_y_sat} !== {1'b1, exp_r.re, exp_r.im, exp_r.sat}) begin
          bad++;
          $display("[TB] FAIL bp_result: got %b/%h/%h/%b expected 1/%h/%h/%b",
                   exp_have, o_y_re, o_y_im, o_y_sat, exp_r.re, exp_r.im, exp_r.sat);
        end
      end else if (o_out_valid && exp_q.size() > 0) begin
        total++;
        if (o_y_re !== exp_q[0].re || o_y_im !== exp_q[0].im || o_y_sat !== exp_q[0].sat) begin
          bad++;
          $display("[TB] FAIL bp_hold: got %h/%h/%b expected %h/%h/%b",
                   o_y_re, o_y_im, o_y_sat, exp_q[0].re, exp_q[0].im, exp_q[0].sat);
        end
      end
      if (sent < 8 && o_in_ready) begin
        sent++;
        md = 2'($urandom_range(0, 3)); ar = rand_op(); ai = rand_op(); br = rand_op(); bi = rand_op();
      end
    end
    total++;
    if (got !== 8 || exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL bp_delivered: got %0d left %0d expected 8 left 0", got, exp_q.size());
    end
  endtask

  task automatic test_random_stream();
    logic ordy;
    $display("[TB] test_random_stream");
    for (int c = 0; c < 320; c++) begin
      ordy = (c >= 300) || ($urandom_range(0, 3) != 0);
      if (c < 300)
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_op(), rand_op(),
             rand_op(), rand_op(), ordy, ($urandom_range(0, 39) == 0));
      else
        step(0, 0, 0, 0, 0, 0, ordy, 1'b0);
      total++;
      if (o_in_ready !== !(o_out_valid && !ordy)) begin
        bad++;
        $display("[TB] FAIL rnd_in_ready: got %b expected %b", o_in_ready, !(o_out_valid && !ordy));
      end
      total++;
      if (o_count !== CW'(exp_cnt) || o_sticky !== exp_sticky) begin
        bad++;
        $display("[TB] FAIL rnd_stats: got %0d/%b expected %0d/%b", o_count, o_sticky, exp_cnt, exp_sticky);
      end
      if (hs) begin
        total++;
        if ({exp_have, o_y_re, o_y_im, o_y_sat} !== {1'b1, exp_r.re, exp_r.im, exp_r.sat}) begin
          bad++;
          $display("[TB] FAIL rnd_result: got %b/%h/%h/%b expected 1/%h/%h/%b",
                   exp_have, o_y_re, o_y_im, o_y_sat, exp_r.re, exp_r.im, exp_r.sat);
        end
      end
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL rnd_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_sat_clr();
    logic found;
    $display("[TB] test_sat_clr");
    step(1, 0, 32'h8000_0000, 0, 32'h8000_0000, 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    step(1, 0, 32'h8000_0000, 0, 32'h8000_0000, 0, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      found = o_out_valid;
    end
    total++;
    if (!found || o_sticky !== 1'b1 || o_count !== CW'(exp_cnt)) begin
      bad++;
      $display("[TB] FAIL clr_setup: got valid=%b sticky=%b count=%0d expected 1/1/%0d",
               found, o_sticky, o_count, exp_cnt);
    end
    step(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    total++;
    if ({exp_have, o_y_sat} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL clr_handshake: got %b/%b expected 1/1", exp_have, o_y_sat);
    end
    step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    total++;
    if (o_count !== 0 || o_sticky !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_priority: got %0d/%b expected 0/0", o_count, o_sticky);
    end
  endtask

  task automatic test_count_ceiling();
    $display("[TB] test_count_ceiling");
    step(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++)
      step(1, 0, 32'h8000_0000, 0, 32'h8000_0000, 0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    total++;
    if (o_count !== CW'(CNT_MAX) || o_sticky !== 1'b1) begin
      bad++;
      $display("[TB] FAIL count_ceiling: got %0d/%b expected %0d/1", o_count, o_sticky, CNT_MAX);
    end
  endtask

  task automatic test_reset_inflight();
    $display("[TB] test_reset_inflight");
    for (int k = 0; k < 3; k++)
      step(1, 0, 32'h8000_0000, 0, 32'h8000_0000, 0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, y_sat, sat_sticky} !== 3'b000 || y_re !== 0 || y_im !== 0 || sat_count !== 0) begin
      bad++;
      $display("[TB] FAIL inflight_reset: got %b/%b/%b/%h/%h/%0d expected all 0",
               out_valid, y_sat, sat_sticky, y_re, y_im, sat_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    model_sticky = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      total++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stale_after_reset: got valid=%b ready=%b expected 0/1", o_out_valid, o_in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random_stream();
    test_sat_clr();
    test_count_ceiling();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
